boolean_function_1_a: RTL and testbench
=======================================

Name: boolean_function_1_a

Overview:
- Evaluates a fixed 3-input Boolean function d = f(a,b,c).
- Default function: d = (a & b) | (~a & c), a 2:1 select where a picks b, otherwise c.
- Provides a combinational output and a registered, valid-qualified copy for synchronous consumers.
- Used as a leaf logic cell in the lab datapath. The exhaustive a/b/c sweep exercises it at 2-time-unit granularity (c toggles every 2, b every 4, a every 8).

Parameters:
- TT, 8'hCA: truth table. Bit index = {a,b,c}; TT[idx] is the output for that input combination. Default gives 000→0, 001→1, 010→0, 011→1, 100→0, 101→0, 110→1, 111→1.
- CNT_W, 16: width of the optional toggle counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- a  in  1  function input, MSB of the index.
- b  in  1  function input, middle bit of the index.
- c  in  1  function input, LSB of the index.
- in_valid  in  1  qualifies a,b,c for the registered path.
- d  out  1  combinational result, TT[{a,b,c}]; no clock dependency.
- d_q  out  1  registered result.
- d_valid  out  1  d_q holds a result captured from a valid input.
- toggle_cnt  out  CNT_W  number of d_q value changes; present only with the optional feature.

Behaviour:
- d is purely combinational: d = TT[{a,b,c}].
  - Changes with zero cycles of latency whenever any input changes, whether or not in_valid is asserted and even during reset.
- Reset (rst=1, asynchronous assert, released synchronously by the next clk edge after deassert):
  - d_q=0, d_valid=0, toggle_cnt=0.
- Each rising clk edge with rst=0:
  - in_valid=1: d_q <= TT[{a,b,c}] and d_valid <= 1.
  - in_valid=0: d_q holds its value and d_valid <= 0.
- Latency: one cycle from valid input to d_q/d_valid.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- X/Z on a, b or c makes d follow simulator semantics. The registered path never sees X inputs when in_valid=1 (caller guarantee).
- Reset asserted mid-stream clears the registered outputs immediately. The first valid input after release produces d_valid one cycle later.

Optional Feature:
- Macro BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN.
- Defined:
  - toggle_cnt port exists and increments by 1 on each clk edge where the next d_q differs from the current d_q.
  - Saturates at all-ones and never wraps.
  - Cleared by rst.
- Undefined:
  - Port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package boolean_function_pkg holds:
  - localparam TT_DEFAULT = 8'hCA;
  - localparam CNT_W_DEFAULT = 16.
- One natural sub-module: bool_lut3, a purely combinational 8-entry LUT, instantiated once for d and reused by the register stage.

Test Plan:
- Exhaustive combinational sweep {a,b,c} = 000..111 -> d = 0,1,0,1,0,0,1,1.
- Reset: rst=1 with in_valid=1 and abc=110 -> d_q=0, d_valid=0 throughout, while d=1 combinationally.
- Registered latency: release rst; drive abc=011 with in_valid=1 for one cycle, then in_valid=0 -> d_q=1 and d_valid=1 exactly one cycle later; next cycle d_valid=0 and d_q stays 1.
- Back-to-back stream: in_valid=1 with abc=001,100,111,000 on consecutive cycles -> d_q = 1,0,1,0 with d_valid held at 1.
- Async reset mid-stream: assert rst between clock edges -> d_q and d_valid drop to 0 without waiting for clk.
- With BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN and CNT_W=2: alternate abc=001/000 for 6 valid cycles -> toggle_cnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/boolean_function_pkg.sv
// Shared constants for the 3-input Boolean function cell.
package boolean_function_pkg;
  localparam logic [7:0] TT_DEFAULT    = 8'hCA;
  localparam int         CNT_W_DEFAULT = 16;
endpackage

// File: rtl/bool_lut3.sv
// Purely combinational 8-entry lookup table; idx = {a,b,c} selects TT[idx].
import boolean_function_pkg::*;

module bool_lut3 #(
  parameter logic [7:0] TT = TT_DEFAULT
) (
  input  logic [2:0] idx,
  output logic       y
);
  assign y = TT[idx];
endmodule

// File: rtl/boolean_function_1_a.sv
// 3-input Boolean function with combinational output and a valid-qualified registered copy.
// Define BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN to add the saturating d_q toggle counter.
import boolean_function_pkg::*;

module boolean_function_1_a #(
`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
  parameter int         CNT_W = CNT_W_DEFAULT,
`endif
  parameter logic [7:0] TT    = TT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             in_valid,
  output logic             d,
  output logic             d_q,
`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
  output logic             d_valid,
  output logic [CNT_W-1:0] toggle_cnt
`else
  output logic             d_valid
`endif
);

  // The single LUT instance feeds both the combinational output and the register stage.
  bool_lut3 #(.TT(TT)) u_lut (
    .idx ({a, b, c}),
    .y   (d)
  );

  logic d_q_next;
  assign d_q_next = in_valid ? d : d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      d_q     <= d_q_next;
      d_valid <= in_valid;
    end
  end

`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
  // Counts d_q transitions; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
    end else if ((d_q_next != d_q) && (toggle_cnt != {CNT_W{1'b1}})) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_boolean_function_1_a.sv
// Self-checking bench for boolean_function_1_a: directed steps plus randomized traffic vs a reference model.
module tb_boolean_function_1_a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, in_valid = 1'b0;
  logic d, d_q, d_valid;

  int tests  = 0;
  int failed = 0;

  logic exp_q = 1'b0;
  logic exp_v = 1'b0;

`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
  localparam int TB_CNT_W = 2;
  logic [TB_CNT_W-1:0] toggle_cnt;
  int exp_cnt = 0;
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;
`endif

  always #5 clk = ~clk;

`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
  boolean_function_1_a #(.CNT_W(TB_CNT_W)) dut (
`else
  boolean_function_1_a dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .c          (c),
    .in_valid   (in_valid),
    .d          (d),
    .d_q        (d_q),
`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
    .d_valid    (d_valid),
    .toggle_cnt (toggle_cnt)
`else
    .d_valid    (d_valid)
`endif
  );

  // Behavioural reference: a selects b, otherwise c.
  function automatic logic ref_d(input logic [2:0] abc);
    return abc[2] ? abc[1] : abc[0];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".d_q"}, d_q, exp_q);
    check({tag, ".d_valid"}, d_valid, exp_v);
`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
    tests++;
    assert (int'(toggle_cnt) == exp_cnt) else begin
      failed++;
      $error("FAIL %s.toggle_cnt observed=%0d expected=%0d", tag, toggle_cnt, exp_cnt);
    end
`endif
  endtask

  // Drive one cycle of input, update the model at the edge, then check.
  task automatic step(input string tag, input logic [2:0] abc, input logic v);
    logic nq;
    @(negedge clk);
    {a, b, c} = abc;
    in_valid  = v;
    #1 check({tag, ".d"}, d, ref_d(abc));
    @(posedge clk);
    nq = v ? ref_d(abc) : exp_q;
`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
    if (nq != exp_q && exp_cnt < CNT_MAX) exp_cnt++;
`endif
    exp_q = nq;
    exp_v = v;
    #1 check_regs(tag);
  endtask

  task automatic model_reset();
    exp_q = 1'b0;
    exp_v = 1'b0;
`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
    exp_cnt = 0;
`endif
  endtask

  initial begin
    logic [7:0] sweep_exp;
    logic [2:0] r_abc;
    logic       r_v;
    sweep_exp = 8'b1100_1010;

    // Reset held with valid traffic present.
    rst = 1'b1;
    {a, b, c} = 3'b110;
    in_valid  = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1 check_regs("reset_hold");
      check("reset_hold.d", d, 1'b1);
    end

    // Exhaustive combinational sweep at 2-unit steps.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #2 check($sformatf("sweep%0d", i), d, sweep_exp[i]);
    end

    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // One-cycle latency, then valid drops and d_q holds.
    step("lat_valid", 3'b011, 1'b1);
    step("lat_hold",  3'b000, 1'b0);

    // Back-to-back stream.
    step("b2b0", 3'b001, 1'b1);
    step("b2b1", 3'b100, 1'b1);
    step("b2b2", 3'b111, 1'b1);
    step("b2b3", 3'b000, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      r_abc = 3'($urandom_range(0, 7));
      r_v   = 1'($urandom_range(0, 1));
      step($sformatf("rand%0d", i), r_abc, r_v);
    end

    // Asynchronous reset between edges.
    step("pre_async", 3'b111, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_regs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_first", 3'b110, 1'b1);
    step("post_rst_idle",  3'b000, 1'b0);

`ifdef BOOLEAN_FUNCTION_1_A_TOGGLE_CNT_EN
    // Saturating toggle counter.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 check_regs("cnt_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      step($sformatf("cnt%0d", i), (i % 2 == 0) ? 3'b001 : 3'b000, 1'b1);
    tests++;
    assert (toggle_cnt == 2'd3) else begin
      failed++;
      $error("FAIL cnt_sat observed=%0d expected=3", toggle_cnt);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
